// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: ALU operation codes, forwarding
// source selector and the EX-stage control bundle.
package riscv_pkg;

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_XOR  = 4'b0101;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SLLI = 4'b0111;
   localparam logic [3:0] ALU_EQ   = 4'b1000;
   localparam logic [3:0] ALU_NE   = 4'b1001;
   localparam logic [3:0] ALU_GT   = 4'b1010;
   localparam logic [3:0] ALU_SLT  = 4'b1100;
   localparam logic [3:0] ALU_SRAI = 4'b1110;
   localparam logic [3:0] ALU_SRLI = 4'b1111;

   typedef enum logic [1:0] {
      FWD_NONE,
      FWD_MEM,
      FWD_WB
   } fwd_sel_e;

   typedef struct packed {
      logic reg_write;
      logic mem_read;
      logic mem_write;
      logic alusrc;
      logic asrc_pc;
   } ex_ctrl_t;

endpackage

// File: rtl/ex_forward_unit.sv
// Operand bypass selection for one EX source register: the youngest
// in-flight writer (MEM) wins over WB, and x0 is never bypassed.
module ex_forward_unit
   import riscv_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5
) (
   input  logic [REG_ADDR_WIDTH-1:0] ex_rs,
   input  logic [DATA_WIDTH-1:0]     reg_data,
   input  logic                      mem_reg_write,
   input  logic [REG_ADDR_WIDTH-1:0] mem_rd,
   input  logic [DATA_WIDTH-1:0]     mem_result,
   input  logic                      wb_reg_write,
   input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
   input  logic [DATA_WIDTH-1:0]     wb_result,
   output logic [DATA_WIDTH-1:0]     fwd_data
);

   fwd_sel_e sel;

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      sel = FWD_NONE;
      if (mem_reg_write && (mem_rd != '0) && (mem_rd == ex_rs))
         sel = FWD_MEM;
      else if (wb_reg_write && (wb_rd != '0) && (wb_rd == ex_rs))
         sel = FWD_WB;
   end

   always_comb begin
      fwd_data = reg_data;
      unique case (sel)
         FWD_MEM: fwd_data = mem_result;
         FWD_WB:  fwd_data = wb_result;
         default: fwd_data = reg_data;
      endcase
   end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding, load-use hazard
// detection and ALU source selection.
module ex_operand_stage
   import riscv_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int OPCODE_LENGTH  = 4,
   parameter int REG_ADDR_WIDTH = 5
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      stall,
   input  logic                      flush,
   input  logic                      id_valid,
   input  logic                      id_reg_write,
   input  logic                      id_mem_read,
   input  logic                      id_mem_write,
   input  logic                      id_alusrc,
   input  logic                      id_asrc_pc,
   input  logic [OPCODE_LENGTH-1:0]  id_alu_op,
   input  logic [DATA_WIDTH-1:0]     id_rs1_data,
   input  logic [DATA_WIDTH-1:0]     id_rs2_data,
   input  logic [DATA_WIDTH-1:0]     id_imm,
   input  logic [DATA_WIDTH-1:0]     id_pc,
   input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
   input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
   input  logic [REG_ADDR_WIDTH-1:0] id_rd,
   input  logic                      mem_reg_write,
   input  logic                      wb_reg_write,
   input  logic [REG_ADDR_WIDTH-1:0] mem_rd,
   input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
   input  logic [DATA_WIDTH-1:0]     mem_result,
   input  logic [DATA_WIDTH-1:0]     wb_result,
   output logic [DATA_WIDTH-1:0]     SrcA,
   output logic [DATA_WIDTH-1:0]     SrcB,
   output logic [OPCODE_LENGTH-1:0]  Operation,
   output logic                      ex_valid,
   output logic                      ex_reg_write,
   output logic                      ex_mem_read,
   output logic                      ex_mem_write,
   output logic [REG_ADDR_WIDTH-1:0] ex_rd,
   output logic [DATA_WIDTH-1:0]     ex_store_data,
   output logic                      load_use_hazard
);

   // An all-zero value of this record is the bubble.
   typedef struct packed {
      logic                      valid;
      ex_ctrl_t                  ctrl;
      logic [OPCODE_LENGTH-1:0]  alu_op;
      logic [REG_ADDR_WIDTH-1:0] rs1;
      logic [REG_ADDR_WIDTH-1:0] rs2;
      logic [REG_ADDR_WIDTH-1:0] rd;
      logic [DATA_WIDTH-1:0]     rs1_data;
      logic [DATA_WIDTH-1:0]     rs2_data;
      logic [DATA_WIDTH-1:0]     imm;
      logic [DATA_WIDTH-1:0]     pc;
   } ex_regs_t;

   ex_regs_t              ex_q;
   ex_regs_t              ex_d;
   ex_regs_t              id_fields;
   logic [DATA_WIDTH-1:0] fwd_a;
   logic [DATA_WIDTH-1:0] fwd_b;

   ex_forward_unit #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_a (
      .ex_rs(ex_q.rs1), .reg_data(ex_q.rs1_data),
      .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
      .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
      .fwd_data(fwd_a)
   );

   ex_forward_unit #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_b (
      .ex_rs(ex_q.rs2), .reg_data(ex_q.rs2_data),
      .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
      .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
      .fwd_data(fwd_b)
   );

   assign load_use_hazard = ex_q.valid && ex_q.ctrl.mem_read && (ex_q.rd != '0) && id_valid &&
                            ((ex_q.rd == id_rs1) || (ex_q.rd == id_rs2));

   always_comb begin
      id_fields = '{
         valid:    id_valid,
         ctrl:     '{reg_write: id_reg_write, mem_read: id_mem_read, mem_write: id_mem_write,
                     alusrc: id_alusrc, asrc_pc: id_asrc_pc},
         alu_op:   id_alu_op,
         rs1:      id_rs1,
         rs2:      id_rs2,
         rd:       id_rd,
         rs1_data: id_rs1_data,
         rs2_data: id_rs2_data,
         imm:      id_imm,
         pc:       id_pc
      };
   end

   // A stalled instruction keeps refreshing its operands so a WB retirement
   // that happens during the stall is not lost once forwarding stops.
   always_comb begin
      ex_d = ex_q;
      if (flush) begin
         ex_d = '0;
      end else if (stall) begin
         ex_d.rs1_data = fwd_a;
         ex_d.rs2_data = fwd_b;
      end else if (load_use_hazard) begin
         ex_d = '0;
      end else begin
         ex_d = id_fields;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) ex_q <= '0;
      else       ex_q <= ex_d;
   end

   assign SrcA          = ex_q.ctrl.asrc_pc ? ex_q.pc  : fwd_a;
   assign SrcB          = ex_q.ctrl.alusrc  ? ex_q.imm : fwd_b;
   assign ex_store_data = fwd_b;
   assign Operation     = ex_q.alu_op;
   assign ex_valid      = ex_q.valid;
   assign ex_reg_write  = ex_q.ctrl.reg_write;
   assign ex_mem_read   = ex_q.ctrl.mem_read;
   assign ex_mem_write  = ex_q.ctrl.mem_write;
   assign ex_rd         = ex_q.rd;

endmodule

// File: doc/ex_operand_stage.md
EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 32, datapath width; OPCODE_LENGTH, 4, ALU operation code width; REG_ADDR_WIDTH, 5, register index width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 stall  input  1  hold current EX contents.
REQ-005 flush  input  1  replace next EX contents with a bubble (branch/jump redirect).
REQ-006 id_valid, id_reg_write, id_mem_read, id_mem_write, id_alusrc, id_asrc_pc  input  1 each  ID-stage valid and control bits.
REQ-007 id_alu_op  input  OPCODE_LENGTH  ALU operation from ALU controller.
REQ-008 id_rs1_data, id_rs2_data, id_imm, id_pc  input  DATA_WIDTH each  ID operands.
REQ-009 id_rs1, id_rs2, id_rd  input  REG_ADDR_WIDTH each  register indices.
REQ-010 mem_reg_write, wb_reg_write  input  1 each; mem_rd, wb_rd  input  REG_ADDR_WIDTH; mem_result, wb_result  input  DATA_WIDTH  forwarding sources.
REQ-011 SrcA, SrcB  output  DATA_WIDTH  ALU operands; Operation  output  OPCODE_LENGTH  ALU operation.
REQ-012 ex_valid, ex_reg_write, ex_mem_read, ex_mem_write  output  1 each; ex_rd  output  REG_ADDR_WIDTH; ex_store_data  output  DATA_WIDTH.
REQ-013 load_use_hazard  output  1  combinational request to hold PC and IF/ID.

Function
REQ-014 EX registers SHALL latch all id_* fields each cycle when flush=0, stall=0, load_use_hazard=0 (latency one cycle ID->EX).
REQ-015 Bubble SHALL be: ex_valid=0, all control bits 0, Operation=4'b0000, ex_rd=0, data registers 0.
REQ-016 Priority SHALL be flush > stall > load_use_hazard > normal load.
REQ-017 flush=1 SHALL load a bubble regardless of stall.
REQ-018 stall=1 (no flush) SHALL hold all fields except rs1/rs2 data registers, which SHALL capture the forwarded values every stalled cycle so a WB retirement during stall is not lost.
REQ-019 load_use_hazard SHALL equal ex_valid & ex_mem_read & (ex_rd!=0) & id_valid & (ex_rd==id_rs1 | ex_rd==id_rs2).
REQ-020 load_use_hazard=1 (no stall/flush) SHALL load a bubble; ID contents re-enter next cycle.
REQ-021 Forward A: if mem_reg_write & mem_rd!=0 & mem_rd==ex_rs1 use mem_result; else if wb_reg_write & wb_rd!=0 & wb_rd==ex_rs1 use wb_result; else registered rs1 data. Forward B identical with ex_rs2.
REQ-022 MEM forwarding SHALL take precedence over WB when both match.
REQ-023 Index 0 SHALL never be forwarded; x0 operand SHALL pass registered data.
REQ-024 SrcA SHALL be registered PC when ex_asrc_pc=1, else forwarded A.
REQ-025 SrcB SHALL be registered immediate when ex_alusrc=1, else forwarded B.
REQ-026 ex_store_data SHALL always be forwarded B, independent of ex_alusrc.
REQ-027 Operation SHALL be the registered id_alu_op, passed unmodified.
REQ-028 SrcA, SrcB, ex_store_data SHALL be combinational from EX registers and forwarding inputs (no extra cycle).

Reset
REQ-029 reset=1 SHALL immediately force EX registers to bubble (REQ-015) regardless of clk, stall, flush.
REQ-030 Following reset deassertion, first rising edge SHALL perform a normal load.
REQ-031 Reset mid-stall SHALL discard the held instruction.

Structure
REQ-032 Shared package riscv_pkg SHALL hold ALU operation constants (AND 0000, OR 0001, ADD 0010, XOR 0101, SUB 0110, SLLI 0111, EQ 1000, NE 1001, GT 1010, SLT 1100, SRAI 1110, SRLI 1111), fwd_sel_e {FWD_NONE, FWD_MEM, FWD_WB}, and struct ex_ctrl_t of control bits.
REQ-033 Forwarding selection SHALL be one combinational sub-module ex_forward_unit, instantiated once per operand.

Verification
REQ-034 ADD x3,x1,x2 with id_rs1_data=5, id_rs2_data=7, no forwarding -> next cycle SrcA=5, SrcB=7, Operation=0010, ex_valid=1.
REQ-035 ex_rs1=4, mem_rd=4 mem_result=0x11, wb_rd=4 wb_result=0x22, both write -> SrcA=0x11; mem_rd=0 with rs1=0 -> registered data.
REQ-036 EX holds LW x5, ID has rs2=5 -> load_use_hazard=1, next cycle ex_valid=0, then dependent instruction enters with SrcB=wb_result.
REQ-037 stall=1 two cycles, wb_rd=ex_rs1 wb_result=0x33 in first stalled cycle only -> after stall SrcA=0x33.
REQ-038 flush=1 and stall=1 same edge -> bubble; reset asserted mid-cycle -> ex_valid=0, Operation=0000 without clock edge.
